// File: rtl/rv32v_mem_load_collector.sv
// Collects per-lane vector load responses, extracts and zero-extends each element
// by the micro-op's element width, and presents one lane-wide writeback word.
module rv32v_mem_load_collector #(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      start,
    input  logic [NUM_LANES-1:0]      lane_mask,
    input  logic [1:0]                veew,
    input  logic [4:0]                vuop_num,
    input  logic                      rsp_valid,
    input  logic [LANE_W-1:0]         rsp_lane,
    input  logic [31:0]               rsp_data,
    input  logic [1:0]                rsp_byte_off,
    input  logic                      flush,
    input  logic                      wb_ready,
    output logic                      wb_valid,
    output logic [NUM_LANES*32-1:0]   wb_data,
    output logic [NUM_LANES-1:0]      wb_mask,
    output logic [4:0]                wb_uop_num,
    output logic                      busy,
    output logic                      err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Element extraction; unknown widths (veew=3) fall back to the full word.
    function automatic logic [31:0] extract_elem(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  eew);
        logic [31:0] elem;
        elem = 32'd0;
        case (eew)
            2'd0: begin
                case (off)
                    2'd0:    elem = {24'd0, word[7:0]};
                    2'd1:    elem = {24'd0, word[15:8]};
                    2'd2:    elem = {24'd0, word[23:16]};
                    2'd3:    elem = {24'd0, word[31:24]};
                    default: elem = 32'd0;
                endcase
            end
            2'd1: begin
                if (off[1]) begin
                    elem = {16'd0, word[31:16]};
                end else begin
                    elem = {16'd0, word[15:0]};
                end
            end
            default: elem = word;
        endcase
        return elem;
    endfunction

    state_e                    state_q, state_d;
    logic [NUM_LANES-1:0]      mask_q, mask_d;
    logic [NUM_LANES-1:0]      recv_q, recv_d;
    logic [1:0]                veew_q, veew_d;
    logic [4:0]                uop_q, uop_d;
    logic [NUM_LANES*32-1:0]   data_q, data_d;
    logic                      err_q, err_d;
    logic                      wb_valid_q;
    logic                      busy_q;

    logic                      accept_s;
    logic                      err_set_s;
    logic [NUM_LANES-1:0]      lane_bit_s;
    logic [NUM_LANES-1:0]      recv_new_s;
    logic [31:0]               elem_s;

    // Next-state computation: flush dominates, then response capture and start acceptance.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        recv_d     = recv_q;
        veew_d     = veew_q;
        uop_d      = uop_q;
        data_d     = data_q;
        err_d      = err_q;
        accept_s   = 1'b0;
        err_set_s  = 1'b0;
        lane_bit_s = {{(NUM_LANES-1){1'b0}}, 1'b1} << rsp_lane;
        recv_new_s = recv_q | lane_bit_s;
        elem_s     = extract_elem(rsp_data, rsp_byte_off, veew_q);

        if (flush) begin
            state_d = IDLE;
            recv_d  = '0;
            data_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    accept_s  = start;
                    err_set_s = rsp_valid;
                end
                COLLECT: begin
                    err_set_s = start;
                    if (rsp_valid && mask_q[rsp_lane] && !recv_q[rsp_lane]) begin
                        recv_d = recv_new_s;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (rsp_lane == LANE_W'(i)) begin
                                data_d[32*i +: 32] = elem_s;
                            end else begin
                                data_d[32*i +: 32] = data_q[32*i +: 32];
                            end
                        end
                        if (recv_new_s == mask_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = COLLECT;
                        end
                    end else if (rsp_valid) begin
                        err_set_s = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        state_d   = IDLE;
                        accept_s  = start;
                        err_set_s = rsp_valid;
                    end else begin
                        err_set_s = rsp_valid | start;
                    end
                end
                default: state_d = IDLE;
            endcase

            // A fresh micro-op starts from a clean slate; an empty mask needs no responses.
            if (accept_s) begin
                mask_d  = lane_mask;
                veew_d  = veew;
                uop_d   = vuop_num;
                recv_d  = '0;
                data_d  = '0;
                state_d = (lane_mask == '0) ? DONE : COLLECT;
                err_d   = (veew == 2'd3) | err_set_s;
            end else begin
                err_d   = err_q | err_set_s;
            end
        end
    end

    // State and output registers; outputs derive from the next state so they never see inputs combinationally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            recv_q     <= '0;
            veew_q     <= 2'd0;
            uop_q      <= 5'd0;
            data_q     <= '0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            recv_q     <= recv_d;
            veew_q     <= veew_d;
            uop_q      <= uop_d;
            data_q     <= data_d;
            err_q      <= err_d;
            wb_valid_q <= (state_d == DONE);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_data    = data_q;
    assign wb_mask    = mask_q;
    assign wb_uop_num = uop_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rv32v_mem_load_collector.sv
// Directed bench for rv32v_mem_load_collector with hand-computed expected values.
module tb_rv32v_mem_load_collector;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic [1:0]  lane_mask;
    logic [1:0]  veew;
    logic [4:0]  vuop_num;
    logic        rsp_valid;
    logic [0:0]  rsp_lane;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_byte_off;
    logic        flush;
    logic        wb_ready;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [1:0]  wb_mask;
    logic [4:0]  wb_uop_num;
    logic        busy;
    logic        err;

    int checks_cnt;
    int errors_cnt;

    rv32v_mem_load_collector #(.NUM_LANES(2)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .lane_mask(lane_mask), .veew(veew),
        .vuop_num(vuop_num), .rsp_valid(rsp_valid), .rsp_lane(rsp_lane),
        .rsp_data(rsp_data), .rsp_byte_off(rsp_byte_off), .flush(flush),
        .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_mask(wb_mask), .wb_uop_num(wb_uop_num), .busy(busy), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [1:0] w, input logic [4:0] tag);
        start = 1'b1; lane_mask = m; veew = w; vuop_num = tag;
        tick();
        start = 1'b0;
    endtask

    task automatic do_rsp(input logic lane, input logic [31:0] d, input logic [1:0] off);
        rsp_valid = 1'b1; rsp_lane = lane; rsp_data = d; rsp_byte_off = off;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic do_handshake();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        checks_cnt = 0; errors_cnt = 0;
        nRST = 1'b0; start = 1'b0; lane_mask = 2'b00; veew = 2'd0; vuop_num = 5'd0;
        rsp_valid = 1'b0; rsp_lane = 1'b0; rsp_data = 32'd0; rsp_byte_off = 2'd0;
        flush = 1'b0; wb_ready = 1'b0;
        #2;
        check_eq("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("rst_wb_data", wb_data, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_err", {63'd0, err}, 64'd0);
        #1 nRST = 1'b1;
        tick();

        // SEW32, both lanes, reverse order
        do_start(2'b11, 2'd2, 5'd5);
        check_eq("s32_busy", {63'd0, busy}, 64'd1);
        do_rsp(1'b1, 32'hDEADBEEF, 2'd0);
        check_eq("s32_not_yet", {63'd0, wb_valid}, 64'd0);
        do_rsp(1'b0, 32'h12345678, 2'd0);
        check_eq("s32_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("s32_data", wb_data, 64'hDEADBEEF_12345678);
        check_eq("s32_uop", {59'd0, wb_uop_num}, 64'd5);
        check_eq("s32_mask", {62'd0, wb_mask}, 64'd3);
        do_handshake();
        check_eq("s32_hs_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("s32_hs_busy", {63'd0, busy}, 64'd0);

        // SEW8 byte extraction
        do_start(2'b11, 2'd0, 5'd7);
        do_rsp(1'b0, 32'hAABBCCDD, 2'd2);
        do_rsp(1'b1, 32'h11223344, 2'd3);
        check_eq("s8_data", wb_data, 64'h00000011_000000BB);
        do_handshake();

        // SEW16 halfword extraction
        do_start(2'b01, 2'd1, 5'd8);
        do_rsp(1'b0, 32'hAABBCCDD, 2'd2);
        check_eq("s16_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("s16_data", wb_data, 64'h00000000_0000AABB);
        do_handshake();

        // Masked-lane response, then single lane1 completion, then response in DONE
        do_start(2'b10, 2'd2, 5'd9);
        check_eq("m10_err0", {63'd0, err}, 64'd0);
        do_rsp(1'b0, 32'h11111111, 2'd0);
        check_eq("m10_masked_err", {63'd0, err}, 64'd1);
        check_eq("m10_masked_data", wb_data, 64'd0);
        check_eq("m10_masked_nvalid", {63'd0, wb_valid}, 64'd0);
        do_rsp(1'b1, 32'hCAFEF00D, 2'd0);
        check_eq("m10_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("m10_data", wb_data, 64'hCAFEF00D_00000000);
        do_rsp(1'b1, 32'h22222222, 2'd0);
        check_eq("m10_dup_data", wb_data, 64'hCAFEF00D_00000000);
        check_eq("m10_dup_err", {63'd0, err}, 64'd1);

        // Back-to-back start with empty mask during handshake
        wb_ready = 1'b1;
        do_start(2'b00, 2'd2, 5'd3);
        wb_ready = 1'b0;
        check_eq("m00_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("m00_busy", {63'd0, busy}, 64'd1);
        check_eq("m00_err_clr", {63'd0, err}, 64'd0);
        check_eq("m00_mask", {62'd0, wb_mask}, 64'd0);
        check_eq("m00_data", wb_data, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("m00_hold_valid", {63'd0, wb_valid}, 64'd1);
            check_eq("m00_hold_uop", {59'd0, wb_uop_num}, 64'd3);
        end
        wb_ready = 1'b1;
        do_start(2'b11, 2'd2, 5'd12);
        wb_ready = 1'b0;
        check_eq("b2b_busy", {63'd0, busy}, 64'd1);
        check_eq("b2b_nvalid", {63'd0, wb_valid}, 64'd0);
        check_eq("b2b_uop", {59'd0, wb_uop_num}, 64'd12);

        // Duplicate lane in COLLECT, then flush
        do_rsp(1'b0, 32'hAAAA0000, 2'd0);
        do_rsp(1'b0, 32'h0000BBBB, 2'd0);
        check_eq("dup_err", {63'd0, err}, 64'd1);
        check_eq("dup_data", wb_data, 64'h00000000_AAAA0000);
        check_eq("dup_nvalid", {63'd0, wb_valid}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_busy", {63'd0, busy}, 64'd0);
        check_eq("fl_err", {63'd0, err}, 64'd0);
        check_eq("fl_data", wb_data, 64'd0);
        do_start(2'b11, 2'd2, 5'd13);
        do_rsp(1'b0, 32'h00000055, 2'd0);
        check_eq("fl_partial", wb_data, 64'h00000000_00000055);
        do_rsp(1'b1, 32'h00000066, 2'd0);
        check_eq("fl_new_data", wb_data, 64'h00000066_00000055);
        do_handshake();

        // veew=3 behaves as SEW32 and flags an error
        do_start(2'b01, 2'd3, 5'd14);
        check_eq("e3_err", {63'd0, err}, 64'd1);
        do_rsp(1'b0, 32'hA5A5A5A5, 2'd1);
        check_eq("e3_data", wb_data, 64'h00000000_A5A5A5A5);
        wb_ready = 1'b1;
        do_start(2'b01, 2'd2, 5'd20);
        wb_ready = 1'b0;
        check_eq("e3_err_clr", {63'd0, err}, 64'd0);

        // start during COLLECT is dropped and flagged
        do_start(2'b11, 2'd0, 5'd21);
        check_eq("sc_err", {63'd0, err}, 64'd1);
        check_eq("sc_uop", {59'd0, wb_uop_num}, 64'd20);
        check_eq("sc_mask", {62'd0, wb_mask}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // start and response in the same IDLE cycle
        start = 1'b1; lane_mask = 2'b11; veew = 2'd2; vuop_num = 5'd22;
        rsp_valid = 1'b1; rsp_lane = 1'b0; rsp_data = 32'h77777777;
        tick();
        start = 1'b0; rsp_valid = 1'b0;
        check_eq("sr_busy", {63'd0, busy}, 64'd1);
        check_eq("sr_err", {63'd0, err}, 64'd1);
        check_eq("sr_data", wb_data, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Asynchronous reset mid-collect
        do_start(2'b11, 2'd2, 5'd1);
        do_rsp(1'b0, 32'h13579BDF, 2'd0);
        #2 nRST = 1'b0;
        #1;
        check_eq("ar_data", wb_data, 64'd0);
        check_eq("ar_busy", {63'd0, busy}, 64'd0);
        check_eq("ar_uop", {59'd0, wb_uop_num}, 64'd0);
        check_eq("ar_mask", {62'd0, wb_mask}, 64'd0);
        #1 nRST = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/rv32v_mem_load_collector.md
# rv32v_mem_load_collector

Downstream neighbour of the vector memory serializer. Receives the per-lane load responses that come back from the LSC, one element at a time and in any lane order, and extracts and zero-extends each element according to the effective element width. Once every unmasked lane of the micro-op has its element, it presents a single lane-wide writeback word to the vector register-file writeback path.

## Interface
- NUM_LANES, 2, number of vector lanes (power of two, ≥2)
- LANE_W, $clog2(NUM_LANES), width of the lane index

- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: serializer has begun a load micro-op
- lane_mask  input  NUM_LANES  lanes expecting data (1 = unmasked); sampled on accepted start
- veew  input  2  vsew_t effective element width (SEW8=0, SEW16=1, SEW32=2); sampled on accepted start
- vuop_num  input  5  micro-op tag; sampled on accepted start
- rsp_valid  input  1  LSC returns data for one lane this cycle
- rsp_lane  input  LANE_W  lane index of the response
- rsp_data  input  32  raw aligned memory word
- rsp_byte_off  input  2  low address bits of the element
- flush  input  1  abort the current micro-op
- wb_ready  input  1  writeback path accepts wb_data
- wb_valid  output  1  assembled result is valid
- wb_data  output  NUM_LANES*32  per-lane elements; lane i at [32*i +: 32]
- wb_mask  output  NUM_LANES  latched lane_mask
- wb_uop_num  output  5  latched vuop_num
- busy  output  1  state ≠ IDLE
- err  output  1  sticky protocol-error flag

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE, start=1: latch lane_mask, veew, vuop_num; clear the received vector and the data registers.
  - Latched mask all zeros: go to DONE.
  - Otherwise: go to COLLECT.
- COLLECT, rsp_valid=1 for a lane with mask=1 and received=0:
  - Write the extracted element into that lane; set its received bit.
  - When received equals the mask, including on this cycle's response, go to DONE.
- Element extraction:
  - SEW8: rsp_data[8*rsp_byte_off +: 8].
  - SEW16: rsp_data[16*rsp_byte_off[1] +: 16]; rsp_byte_off[0] is ignored.
  - SEW32: rsp_data; rsp_byte_off is ignored.
  - The result is zero-extended to 32 bits. veew=3 is treated as SEW32 and sets err.
- DONE:
  - wb_valid=1; wb_data, wb_mask and wb_uop_num hold steady until the handshake.
  - On wb_valid & wb_ready: go to IDLE.
  - If start is also high in the handshake cycle, it is accepted as if in IDLE (back-to-back micro-ops).
- Masked lanes always output 0 in wb_data.
- err (sticky, set on any of the following):
  - rsp_valid in IDLE or DONE.
  - rsp_valid to a masked lane.
  - rsp_valid to an already-received lane.
  - start outside an accept slot.
  - veew=3.
- Offending responses and starts are dropped; state and data are unchanged.
- err clears only on an accepted start, flush, or reset.
- flush: from any state, next state is IDLE. Received vector, data registers and err are cleared. flush has priority over start, rsp_valid and the wb handshake in the same cycle.

## Timing
- Reset, asynchronous: state=IDLE; wb_valid=0, wb_data=0, wb_mask=0, wb_uop_num=0, busy=0, err=0. Reset mid-collect discards all partial data.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency:
  - Last required response in cycle t: wb_valid=1 in cycle t+1.
  - start with an all-zero mask in cycle t: wb_valid=1 in cycle t+1.
- busy rises the cycle after an accepted start. It falls the cycle after the handshake or flush, unless a back-to-back start was accepted.
- Response and start in the same IDLE cycle: start is accepted; the response is an error (err=1 the next cycle).
- At most one response per cycle. Responses may arrive in any lane order and with any gap.

## Test plan
- NUM_LANES=2, SEW32, mask=2'b11, responses lane1=0xDEADBEEF then lane0=0x12345678:
  - wb_valid the cycle after the 2nd response.
  - wb_data={0xDEADBEEF,0x12345678}, wb_uop_num equals the start tag.
- SEW8, mask=2'b11:
  - Lane0 rsp_data=0xAABBCCDD, off=2 → lane0=0x000000BB.
  - Lane1 rsp_data=0x11223344, off=3 → lane1=0x00000011.
  - SEW16 with off=2 on 0xAABBCCDD → 0x0000AABB.
- mask=2'b10, single lane1 response:
  - DONE with lane0 data=0.
  - A second lane1 response or a lane0 response → err=1; data unchanged.
- mask=2'b00 start → wb_valid next cycle, wb_mask=0. Hold wb_ready=0 for 3 cycles → outputs stable. wb_ready=1 together with a new start → new micro-op accepted, busy stays 1.
- Flush after one of two responses:
  - Next cycle IDLE, busy=0, err=0.
  - A following start/response sequence produces correct data with no stale lane contents.
- Assert nRST low mid-COLLECT → all outputs 0 immediately, independent of CLK.
